// File: rtl/softmax_loader.sv
`timescale 1ns/1ps
// softmax_loader
// Two-pass front end for a softmax unit. Pass one (SCAN) reads all N
// elements of a vector from a zero-latency memory and finds their maximum.
// Pass two (STREAM) reads the vector again and emits (max - element) for
// every element over a valid/ready handshake, in address order.
//
// Ports
//   clk        : single clock, rising edge
//   reset      : asynchronous, active-high; aborts any vector in progress
//   start      : begin one vector (only looked at while idle)
//   data       : element read from memory, valid while data_req=1
//   data_req   : memory read request for address data_addr
//   data_addr  : element address 0..N-1
//   diff_valid : diff_data/diff_last hold an element
//   diff_ready : downstream accepts the element this cycle
//   diff_data  : max_val minus element
//   diff_last  : marks element N-1
//   max_val    : maximum of the vector, held from end of SCAN
//   busy       : high whenever not idle
//   done       : one-cycle pulse after the last element is accepted
module softmax_loader #(
   parameter int N  = 256,
   parameter int AW = 9
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic [7:0]    data,
   output logic          data_req,
   output logic [AW-1:0] data_addr,
   output logic          diff_valid,
   input  logic          diff_ready,
   output logic [7:0]    diff_data,
   output logic          diff_last,
   output logic [7:0]    max_val,
   output logic          busy,
   output logic          done
);

   typedef enum logic [1:0] {IDLE, SCAN, STREAM, DONE} state_t;

   localparam logic [AW-1:0] LAST_ADDR = AW'(N - 1);

   state_t     state;
   logic [7:0] run_max;
   logic       all_req;   // every element has been requested during STREAM
   logic       at_last;
   logic       xfer;
   logic [7:0] scan_max;

   // The max is taken over the same vector, so m >= d always holds and the
   // plain modular subtraction never wraps.
   function automatic logic [7:0] max_minus(input logic [7:0] m, input logic [7:0] d);
      return m - d;
   endfunction

   assign at_last  = (data_addr == LAST_ADDR);
   assign xfer     = diff_valid && diff_ready;
   assign scan_max = (data >= run_max) ? data : run_max;
   assign busy     = (state != IDLE);
   assign done     = (state == DONE);

   // A new element may only be fetched when the output register is empty or
   // being emptied this cycle, which keeps the output stable during stalls.
   always_comb begin
      data_req = 1'b0;
      unique case (state)
         SCAN:    data_req = 1'b1;
         STREAM:  data_req = !all_req && (!diff_valid || diff_ready);
         default: data_req = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         run_max    <= 8'd0;
         all_req    <= 1'b0;
         data_addr  <= '0;
         diff_valid <= 1'b0;
         diff_data  <= 8'd0;
         diff_last  <= 1'b0;
         max_val    <= 8'd0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  state     <= SCAN;
                  run_max   <= 8'd0;
                  all_req   <= 1'b0;
                  data_addr <= '0;
               end
            end
            SCAN: begin
               run_max <= scan_max;
               if (at_last) begin
                  state     <= STREAM;
                  max_val   <= scan_max;
                  data_addr <= '0;
               end else begin
                  data_addr <= data_addr + 1'b1;
               end
            end
            STREAM: begin
               if (data_req) begin
                  diff_data  <= max_minus(max_val, data);
                  diff_valid <= 1'b1;
                  diff_last  <= at_last;
                  if (at_last) all_req <= 1'b1;
                  else         data_addr <= data_addr + 1'b1;
               end else if (xfer) begin
                  diff_valid <= 1'b0;
                  diff_last  <= 1'b0;
                  if (diff_last) state <= DONE;
               end
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/softmax_loader.md
SOFTMAX_LOADER -- requirements
Module: softmax_loader

Interface
REQ-001 SHALL have parameter N, default 256: number of input elements per softmax vector.
REQ-002 SHALL have parameter AW, default 9: address width of data_addr.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  begin processing one vector; sampled only in IDLE.
REQ-006 SHALL have port data  input  8  unsigned element from input memory; valid only when data_req=1; high-Z otherwise.
REQ-007 SHALL have port data_req  output  1  read request to input memory.
REQ-008 SHALL have port data_addr  output  AW  element address, 0..N-1.
REQ-009 SHALL have port diff_valid  output  1  diff_data holds a valid element.
REQ-010 SHALL have port diff_ready  input  1  downstream (STAR exp/LUT stage) accepts diff_data.
REQ-011 SHALL have port diff_data  output  8  max_val minus element, unsigned.
REQ-012 SHALL have port diff_last  output  1  marks element N-1.
REQ-013 SHALL have port max_val  output  8  maximum of the current vector.
REQ-014 SHALL have ports busy and done  output  1 each  busy=1 outside IDLE; done is a one-cycle completion pulse.

Function
REQ-015 SHALL implement states IDLE, SCAN, STREAM, DONE.
REQ-016 IDLE: start=1 at an edge -> SCAN; clear the running max to 0; set data_addr=0.
REQ-017 SCAN: data_req=1 every cycle; data_addr increments 0..N-1, one per cycle; data sampled at the rising edge ending the request cycle (zero-latency memory).
REQ-018 SCAN: running max updated with data when data >= running max; after address N-1 -> STREAM with data_addr=0; max_val loaded with final max.
REQ-019 STREAM: data_req = (!diff_valid || diff_ready) while unrequested elements remain; data_addr advances only on a requested cycle.
REQ-020 STREAM: on a requested cycle, diff_data <= max_val - data, diff_valid <= 1, diff_last <= (data_addr == N-1), all at the next edge.
REQ-021 Transfer occurs on diff_valid && diff_ready; diff_valid clears after a transfer unless a new element loads in the same edge.
REQ-022 While diff_valid=1 and diff_ready=0, diff_data and diff_last SHALL hold stable and data_req SHALL be 0.
REQ-023 Transfer with diff_last=1 -> DONE; DONE asserts done=1 for exactly one cycle, then IDLE.
REQ-024 With diff_ready held 1, done SHALL assert in cycle 2N+2 after the edge sampling start.
REQ-025 max_val SHALL hold its value from end of SCAN until the next start is accepted.
REQ-026 start SHALL be ignored outside IDLE; data SHALL never be sampled when data_req=0.
REQ-027 data_addr SHALL hold its last value when data_req=0; no wrap beyond N-1.
REQ-028 diff_data SHALL never underflow (max >= every element by construction).

Reset
REQ-029 reset=1 SHALL immediately force IDLE and data_req=0, data_addr=0, diff_valid=0, diff_data=0, diff_last=0, max_val=0, busy=0, done=0, independent of clk.
REQ-030 reset asserted mid-SCAN or mid-STREAM SHALL abort the vector; the next start restarts from SCAN at address 0.

Verification
REQ-031 Ramp data[i]=i, diff_ready=1 -> max_val=255; diff_data sequence 255..0; diff_last only on 256th; done in cycle 514.
REQ-032 All elements 0x40 -> max_val=0x40; all 256 diff_data=0x00.
REQ-033 Elements 0x10 except data[200]=0xFF -> max_val=0xFF; diff_data=0xEF everywhere except index 200 = 0x00.
REQ-034 diff_ready toggling 1/0 each cycle -> all 256 elements delivered in address order, no duplicates/drops, outputs stable and data_req=0 during stalls.
REQ-035 reset pulsed after 100th STREAM transfer -> all outputs 0 in the same cycle; new start reproduces REQ-031 results exactly.
REQ-036 start pulsed during SCAN and during STREAM -> no effect; exactly one done pulse per accepted start.
